// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX stage: FSM encoding, default control-bit
// positions and the bubble value of the EX-stage flags.
package id_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam int MEMREAD_BIT_DEF  = 3;
   localparam int REGWRITE_BIT_DEF = 1;

   typedef struct packed {
      logic valid;
      logic halt;
   } ex_flags_t;

   localparam ex_flags_t EX_BUBBLE = '{valid: 1'b0, halt: 1'b0};

endpackage

// File: rtl/id_ex_hazard_stage_hazard_detect_unit.sv
// Combinational hazard detection for the instruction in ID against the
// instructions currently in EX and MEM.
module hazard_detect_unit #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_eval,
   input  logic                  i_uses_rs,
   input  logic                  i_uses_rt,
   input  logic [REG_ADDR_W-1:0] i_reg_rs,
   input  logic [REG_ADDR_W-1:0] i_reg_rt,
   input  logic                  i_is_branch,
   input  logic                  i_ex_valid,
   input  logic                  i_ex_mem_read,
   input  logic                  i_ex_reg_write,
   input  logic [REG_ADDR_W-1:0] i_ex_reg_dest,
   input  logic                  i_mem_mem_read,
   input  logic [REG_ADDR_W-1:0] i_mem_reg_dest,
   output logic                  o_load_use,
   output logic                  o_br_ex,
   output logic                  o_br_mem
);

   // Register 0 is hard-wired, so a write to it can never create a dependency.
   function automatic logic src_match(input logic [REG_ADDR_W-1:0] d,
                                      input logic uses_rs, input logic uses_rt,
                                      input logic [REG_ADDR_W-1:0] rs,
                                      input logic [REG_ADDR_W-1:0] rt);
      return (d != '0) && ((uses_rs && (rs == d)) || (uses_rt && (rt == d)));
   endfunction

   logic match_ex;
   logic match_mem;

   always_comb begin
      match_ex   = src_match(i_ex_reg_dest,  i_uses_rs, i_uses_rt, i_reg_rs, i_reg_rt);
      match_mem  = src_match(i_mem_reg_dest, i_uses_rs, i_uses_rt, i_reg_rs, i_reg_rt);
      o_load_use = i_eval && i_ex_valid && i_ex_mem_read && match_ex;
      o_br_ex    = i_eval && i_is_branch && i_ex_valid && i_ex_reg_write && match_ex;
      o_br_mem   = i_eval && i_is_branch && i_mem_mem_read && match_mem;
   end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with hazard stalls, bubble insertion and a halt
// drain FSM. All state advances on the falling clock edge.
module id_ex_hazard_stage
   import id_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 11,
   parameter int REG_ADDR_W   = 5,
   parameter int CTRL_W       = 16,
   parameter int MEMREAD_BIT  = MEMREAD_BIT_DEF,
   parameter int REGWRITE_BIT = REGWRITE_BIT_DEF,
   parameter int DRAIN_CYCLES = 3,
   parameter int PERF_W       = 16
) (
   input  logic                  i_clock,
   input  logic                  i_soft_reset,
   input  logic                  i_enable_pipeline,
   input  logic                  i_valid,
   input  logic                  i_flush,
   input  logic [CTRL_W-1:0]     i_ctrl,
   input  logic [DATA_W-1:0]     i_data_A,
   input  logic [DATA_W-1:0]     i_data_B,
   input  logic [DATA_W-1:0]     i_imm,
   input  logic [REG_ADDR_W-1:0] i_reg_rs,
   input  logic [REG_ADDR_W-1:0] i_reg_rt,
   input  logic [REG_ADDR_W-1:0] i_reg_dest,
   input  logic                  i_uses_rs,
   input  logic                  i_uses_rt,
   input  logic                  i_is_branch,
   input  logic [ADDR_W-1:0]     i_pc_next,
   input  logic                  i_halt,
   input  logic                  i_mem_mem_read,
   input  logic [REG_ADDR_W-1:0] i_mem_reg_dest,
   output logic                  o_valid,
   output logic [CTRL_W-1:0]     o_ctrl,
   output logic [DATA_W-1:0]     o_data_A,
   output logic [DATA_W-1:0]     o_data_B,
   output logic [DATA_W-1:0]     o_imm,
   output logic [REG_ADDR_W-1:0] o_reg_rs,
   output logic [REG_ADDR_W-1:0] o_reg_rt,
   output logic [REG_ADDR_W-1:0] o_reg_dest,
   output logic [ADDR_W-1:0]     o_pc_next,
   output logic                  o_halt_detected,
   output logic                  o_stall,
   output logic                  o_halt_done,
   output logic [1:0]            o_state,
   output logic [PERF_W-1:0]     o_stall_count
);

   localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   generate
      if (DRAIN_CYCLES < 1) begin : g_bad_drain
         $fatal(1, "id_ex_hazard_stage: DRAIN_CYCLES must be at least 1");
      end
   endgenerate

   typedef struct packed {
      logic [CTRL_W-1:0]     ctrl;
      logic [DATA_W-1:0]     data_a;
      logic [DATA_W-1:0]     data_b;
      logic [DATA_W-1:0]     imm;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] dest;
      logic [ADDR_W-1:0]     pc_next;
   } ex_data_t;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   ex_flags_t         flags_d, flags_q;
   ex_data_t          data_d, data_q;
   state_t            state_d, state_q;
   logic [CNT_W-1:0]  drain_d, drain_q;
   logic              halt_done_d, halt_done_q;
   logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;

   logic eval;
   logic load_use, br_ex, br_mem, hazard;

   assign eval = i_valid && !i_flush && (state_q == ST_RUN);

   hazard_detect_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .i_eval         (eval),
      .i_uses_rs      (i_uses_rs),
      .i_uses_rt      (i_uses_rt),
      .i_reg_rs       (i_reg_rs),
      .i_reg_rt       (i_reg_rt),
      .i_is_branch    (i_is_branch),
      .i_ex_valid     (flags_q.valid),
      .i_ex_mem_read  (data_q.ctrl[MEMREAD_BIT]),
      .i_ex_reg_write (data_q.ctrl[REGWRITE_BIT]),
      .i_ex_reg_dest  (data_q.dest),
      .i_mem_mem_read (i_mem_mem_read),
      .i_mem_reg_dest (i_mem_reg_dest),
      .o_load_use     (load_use),
      .o_br_ex        (br_ex),
      .o_br_mem       (br_mem)
   );

   assign hazard  = load_use || br_ex || br_mem;
   assign o_stall = hazard || (state_q != ST_RUN);

   always_comb begin
      flags_d     = flags_q;
      data_d      = data_q;
      state_d     = state_q;
      drain_d     = drain_q;
      halt_done_d = halt_done_q;
      stall_cnt_d = stall_cnt_q;

      if (i_enable_pipeline) begin
         // Default to a bubble; only a clean RUN-state capture overrides it.
         flags_d = EX_BUBBLE;
         data_d  = '0;
         if (i_flush) begin
         end else if (hazard) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
         end else if (state_q == ST_RUN) begin
            flags_d.valid = i_valid;
            flags_d.halt  = i_valid && i_halt;
            data_d.ctrl    = i_ctrl;
            data_d.data_a  = i_data_A;
            data_d.data_b  = i_data_B;
            data_d.imm     = i_imm;
            data_d.rs      = i_reg_rs;
            data_d.rt      = i_reg_rt;
            data_d.dest    = i_reg_dest;
            data_d.pc_next = i_pc_next;
         end

         unique case (state_q)
            ST_RUN: begin
               if (!i_flush && !hazard && i_valid && i_halt) begin
                  state_d = ST_DRAIN;
                  drain_d = CNT_W'(DRAIN_CYCLES);
               end
            end
            ST_DRAIN: begin
               if (drain_q <= CNT_W'(1)) begin
                  state_d     = ST_HALTED;
                  drain_d     = '0;
                  halt_done_d = 1'b1;
               end else begin
                  drain_d = drain_q - CNT_W'(1);
               end
            end
            ST_HALTED: halt_done_d = 1'b1;
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(negedge i_clock or negedge i_soft_reset) begin
      if (!i_soft_reset) begin
         flags_q     <= EX_BUBBLE;
         data_q      <= '0;
         state_q     <= ST_RUN;
         drain_q     <= '0;
         halt_done_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         flags_q     <= flags_d;
         data_q      <= data_d;
         state_q     <= state_d;
         drain_q     <= drain_d;
         halt_done_q <= halt_done_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_valid         = flags_q.valid;
   assign o_halt_detected = flags_q.halt;
   assign o_ctrl          = data_q.ctrl;
   assign o_data_A        = data_q.data_a;
   assign o_data_B        = data_q.data_b;
   assign o_imm           = data_q.imm;
   assign o_reg_rs        = data_q.rs;
   assign o_reg_rt        = data_q.rt;
   assign o_reg_dest      = data_q.dest;
   assign o_pc_next       = data_q.pc_next;
   assign o_halt_done     = halt_done_q;
   assign o_state         = state_q;
   assign o_stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: load-use and branch stalls, r0 guard,
// enable freeze, flush, halt drain and asynchronous reset.
module tb_id_ex_hazard_stage;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        vld, flush;
   logic [15:0] ctrl;
   logic [31:0] da, db, imm;
   logic [4:0]  rs, rt, dest;
   logic        urs, urt, br;
   logic [10:0] pc;
   logic        halt;
   logic        mem_rd;
   logic [4:0]  mem_dest;

   logic        o_valid;
   logic [15:0] o_ctrl;
   logic [31:0] o_da, o_db, o_imm;
   logic [4:0]  o_rs, o_rt, o_dest;
   logic [10:0] o_pc;
   logic        o_halt_det, o_stall, o_halt_done;
   logic [1:0]  o_state;
   logic [15:0] o_cnt;

   int n_total = 0;
   int n_bad   = 0;

   localparam logic [15:0] C_LW  = 16'h000A;
   localparam logic [15:0] C_ADD = 16'h0002;

   id_ex_hazard_stage dut (
      .i_clock(clk), .i_soft_reset(rst_n), .i_enable_pipeline(en),
      .i_valid(vld), .i_flush(flush), .i_ctrl(ctrl),
      .i_data_A(da), .i_data_B(db), .i_imm(imm),
      .i_reg_rs(rs), .i_reg_rt(rt), .i_reg_dest(dest),
      .i_uses_rs(urs), .i_uses_rt(urt), .i_is_branch(br),
      .i_pc_next(pc), .i_halt(halt),
      .i_mem_mem_read(mem_rd), .i_mem_reg_dest(mem_dest),
      .o_valid(o_valid), .o_ctrl(o_ctrl),
      .o_data_A(o_da), .o_data_B(o_db), .o_imm(o_imm),
      .o_reg_rs(o_rs), .o_reg_rt(o_rt), .o_reg_dest(o_dest),
      .o_pc_next(o_pc), .o_halt_detected(o_halt_det), .o_stall(o_stall),
      .o_halt_done(o_halt_done), .o_state(o_state), .o_stall_count(o_cnt)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic instr(input logic v, input logic [15:0] c, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic us,
                        input logic ut, input logic b, input logic h,
                        input logic [31:0] a, input logic [31:0] bb, input logic [10:0] p);
      vld = v; ctrl = c; rs = s; rt = t; dest = d; urs = us; urt = ut;
      br = b; halt = h; da = a; db = bb; imm = a ^ bb; pc = p;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; flush = 1'b0; mem_rd = 1'b0; mem_dest = '0;
      instr(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_ctrl",  o_ctrl, 0);
      chk("rst_state", o_state, 0);
      chk("rst_cnt",   o_cnt, 0);
      chk("rst_done",  o_halt_done, 0);
      chk("rst_stall", o_stall, 0);
      rst_n = 1'b1;

      // LW r2 followed by dependent ADD
      instr(1, C_LW, 1, 0, 2, 1, 0, 0, 0, 32'h11, 32'h0, 11'd1);
      chk("lw_nostall", o_stall, 0);
      tick();
      chk("lw_valid", o_valid, 1);
      chk("lw_ctrl",  o_ctrl, C_LW);
      chk("lw_dest",  o_dest, 2);
      chk("lw_da",    o_da, 32'h11);
      chk("lw_pc",    o_pc, 1);
      instr(1, C_ADD, 2, 4, 3, 1, 1, 0, 0, 32'h22, 32'h44, 11'd2);
      chk("lu_stall", o_stall, 1);
      tick();
      chk("lu_bub_valid", o_valid, 0);
      chk("lu_bub_ctrl",  o_ctrl, 0);
      chk("lu_bub_dest",  o_dest, 0);
      chk("lu_bub_da",    o_da, 0);
      chk("lu_cnt",       o_cnt, 1);
      chk("lu_release",   o_stall, 0);
      tick();
      chk("add_valid", o_valid, 1);
      chk("add_dest",  o_dest, 3);
      chk("add_db",    o_db, 32'h44);
      chk("add_imm",   o_imm, 32'h66);
      chk("add_cnt",   o_cnt, 1);

      // LW r5 then BEQ r5,r0: load-use then MEM-stage load stall
      instr(1, C_LW, 1, 0, 5, 1, 0, 0, 0, 32'h5, 32'h0, 11'd3);
      tick();
      instr(1, 16'h0, 5, 0, 0, 1, 1, 1, 0, 32'h55, 32'h0, 11'd4);
      chk("beq_lu_stall", o_stall, 1);
      tick();
      chk("beq_bub1", o_valid, 0);
      chk("beq_cnt1", o_cnt, 2);
      mem_rd = 1'b1; mem_dest = 5'd5; #1;
      chk("beq_mem_stall", o_stall, 1);
      tick();
      chk("beq_bub2", o_valid, 0);
      chk("beq_cnt2", o_cnt, 3);
      mem_rd = 1'b0; mem_dest = 5'd0; #1;
      chk("beq_release", o_stall, 0);
      tick();
      chk("beq_valid", o_valid, 1);
      chk("beq_rs",    o_rs, 5);
      chk("beq_cnt3",  o_cnt, 3);

      // ALU result in EX: only a branch consumer stalls
      instr(1, C_ADD, 1, 1, 6, 1, 1, 0, 0, 32'h6, 32'h6, 11'd5);
      tick();
      instr(1, 16'h0, 6, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, 11'd6);
      chk("brex_stall", o_stall, 1);
      instr(1, C_ADD, 6, 0, 7, 1, 0, 0, 0, 32'h0, 32'h0, 11'd6);
      chk("alu_fwd_nostall", o_stall, 0);

      // register 0 never matches
      instr(1, C_LW, 1, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 11'd7);
      tick();
      mem_rd = 1'b1; mem_dest = 5'd0;
      instr(1, 16'h0, 0, 0, 0, 1, 1, 1, 0, 32'h0, 32'h0, 11'd8);
      chk("r0_nostall", o_stall, 0);
      tick();
      chk("r0_valid", o_valid, 1);
      mem_rd = 1'b0;

      // freeze during a load-use hazard
      instr(1, C_LW, 1, 0, 7, 1, 0, 0, 0, 32'h7, 32'h0, 11'd9);
      tick();
      instr(1, C_ADD, 7, 0, 8, 1, 0, 0, 0, 32'h8, 32'h0, 11'd10);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("frz_stall", o_stall, 1);
         chk("frz_valid", o_valid, 1);
         chk("frz_dest",  o_dest, 7);
         chk("frz_cnt",   o_cnt, 3);
      end
      en = 1'b1;
      tick();
      chk("frz_bub", o_valid, 0);
      chk("frz_cnt_inc", o_cnt, 4);
      tick();
      chk("frz_capt", o_dest, 8);

      // flush together with a hazard
      instr(1, C_LW, 1, 0, 9, 1, 0, 0, 0, 32'h9, 32'h0, 11'd11);
      tick();
      flush = 1'b1;
      instr(1, C_ADD, 9, 0, 10, 1, 0, 0, 0, 32'h0, 32'h0, 11'd12);
      chk("fl_nostall", o_stall, 0);
      tick();
      chk("fl_bub",  o_valid, 0);
      chk("fl_cnt",  o_cnt, 4);
      instr(1, 16'h0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 11'd13);
      tick();
      chk("fl_halt_det", o_halt_det, 0);
      chk("fl_halt_state", o_state, 0);
      flush = 1'b0;

      // HALT then reset mid-drain
      tick();
      chk("h1_det",   o_halt_det, 1);
      chk("h1_state", o_state, 1);
      instr(1, C_ADD, 1, 1, 3, 1, 1, 0, 0, 32'h1, 32'h1, 11'd14);
      tick();
      chk("h1_drain_state", o_state, 1);
      chk("h1_drain_valid", o_valid, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", o_state, 0);
      chk("arst_cnt",   o_cnt, 0);
      chk("arst_valid", o_valid, 0);
      chk("arst_stall", o_stall, 0);
      rst_n = 1'b1;

      // full halt drain
      instr(1, 16'h0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 11'd15);
      tick();
      chk("h2_det",   o_halt_det, 1);
      chk("h2_valid", o_valid, 1);
      chk("h2_state", o_state, 1);
      instr(1, C_ADD, 1, 1, 3, 1, 1, 0, 0, 32'h1, 32'h1, 11'd16);
      chk("h2_stall", o_stall, 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("h2_drain_state", o_state, 1);
         chk("h2_drain_valid", o_valid, 0);
         chk("h2_drain_det",   o_halt_det, 0);
         chk("h2_drain_done",  o_halt_done, 0);
         chk("h2_drain_stall", o_stall, 1);
      end
      tick();
      chk("h2_halted", o_state, 2);
      chk("h2_done",   o_halt_done, 1);
      chk("h2_valid0", o_valid, 0);
      tick();
      chk("h2_hold_state", o_state, 2);
      chk("h2_hold_stall", o_stall, 1);
      chk("h2_hold_cnt",   o_cnt, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
Parametrised ID/EX pipeline stage with integrated hazard detection, bubble insertion and halt draining. It registers the decoded instruction bundle from the ID combinational logic into EX. It stalls IF/ID on load-use and branch-in-ID data hazards. After a halt instruction it drains the pipeline through a small FSM. It sits between the decoder/register-file/control group and the EX stage, and replaces the fixed-width ID output register set.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 11, PC/instruction address width
REG_ADDR_W, 5, register index width
CTRL_W, 16, width of the opaque control bundle (RegDst, RegWrite, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, ALUCtrl, byte select packed)
MEMREAD_BIT, 3, index of MemRead inside the control bundle
REGWRITE_BIT, 1, index of RegWrite inside the control bundle
DRAIN_CYCLES, 3, cycles to drain EX/MEM/WB after a halt is issued
PERF_W, 16, width of the stall performance counter

Ports:
i_clock  in  1  stage clock; all registers update on the falling edge
i_soft_reset  in  1  asynchronous active-low reset
i_enable_pipeline  in  1  global advance enable (debug step); 0 freezes every register and counter
i_valid  in  1  ID holds a real instruction
i_flush  in  1  discard the ID instruction (insert bubble)
i_ctrl  in  CTRL_W  decoded control bundle
i_data_A / i_data_B  in  DATA_W  register-file read data
i_imm  in  DATA_W  sign-extended immediate
i_reg_rs / i_reg_rt  in  REG_ADDR_W  source indices
i_reg_dest  in  REG_ADDR_W  destination index after RegDst resolution
i_uses_rs / i_uses_rt  in  1  instruction really reads rs / rt
i_is_branch  in  1  instruction compares registers in ID (BEQ/BNE/JR/JALR)
i_pc_next  in  ADDR_W  PC+1 from IF
i_halt  in  1  ID instruction is HALT
i_mem_mem_read  in  1  MEM-stage instruction is a load
i_mem_reg_dest  in  REG_ADDR_W  MEM-stage destination
o_valid  out  1  EX-stage instruction valid
o_ctrl  out  CTRL_W  registered control bundle
o_data_A / o_data_B / o_imm  out  DATA_W  registered operands
o_reg_rs / o_reg_rt / o_reg_dest  out  REG_ADDR_W  registered indices
o_pc_next  out  ADDR_W  registered PC+1
o_halt_detected  out  1  EX-stage instruction is HALT
o_stall  out  1  combinational: hold PC and IF/ID this cycle
o_halt_done  out  1  pipeline fully drained after halt (sticky)
o_state  out  2  FSM state (RUN=0, DRAIN=1, HALTED=2)
o_stall_count  out  PERF_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, i_soft_reset=0): all outputs 0, state RUN, drain counter 0, o_stall_count 0.
- Latency: 1 falling edge from ID inputs to outputs.
- Register-0 guard: a dest of 0 never matches.
- Hazard (evaluated only when i_valid & ~i_flush & state RUN); src_match(d) = (i_uses_rs & i_reg_rs==d) | (i_uses_rt & i_reg_rt==d):
  - load_use: o_valid & o_ctrl[MEMREAD_BIT] & src_match(o_reg_dest)
  - br_ex: i_is_branch & o_valid & o_ctrl[REGWRITE_BIT] & src_match(o_reg_dest)
  - br_mem: i_is_branch & i_mem_mem_read & src_match(i_mem_reg_dest)
  - hazard = load_use | br_ex | br_mem.
  - A load followed by a dependent branch therefore stalls 2 cycles.
- o_stall = hazard | (state != RUN).
- Update priority on each enabled falling edge:
  - flush first: bubble.
  - Else if hazard: bubble, and o_stall_count increments (saturates at all-ones).
  - Else if state != RUN: bubble.
  - Else: capture all inputs, with o_valid = i_valid.
- Bubble: o_valid=0, o_ctrl=0, o_halt_detected=0. Data and index fields are also cleared to 0.
- i_enable_pipeline=0: everything holds, including FSM and counters. o_stall is still computed.
- FSM:
  - RUN -> DRAIN when a valid, unflushed, unstalled i_halt is captured (o_halt_detected=1 next cycle); drain counter loads DRAIN_CYCLES.
  - DRAIN: counter decrements per enabled edge; at 1 -> HALTED.
  - HALTED: o_halt_done=1; stays until reset.
- Flush of a HALT in ID: no transition.
- Reset mid-DRAIN: returns to RUN immediately.
- DRAIN_CYCLES=0 is illegal; an assertion fires at elaboration.

Decomposition:
- Shared package id_pkg: FSM state encoding (RUN/DRAIN/HALTED), default MEMREAD_BIT/REGWRITE_BIT positions, and a bubble constant.
- One natural sub-module, hazard_detect_unit: purely combinational; produces load_use/br_ex/br_mem/hazard from the index, uses and ctrl-bit inputs.
- The pipeline register, FSM and perf counter stay in the top.

Test Plan:
- LW r2 in EX (MemRead=1, dest=2), then ADD r3,r2,r4 in ID with uses_rs -> o_stall=1 for 1 cycle, o_valid=0 bubble, o_stall_count=1; next cycle ADD captured.
- LW r5, then BEQ r5,r0 -> cycle1 load_use stall, cycle2 br_mem stall (i_mem_mem_read=1, dest 5), cycle3 BEQ captured; count=2.
- ADD r0 dest with dependent consumer reading r0 -> no stall.
- HALT captured with DRAIN_CYCLES=3 -> o_halt_detected=1 one cycle, o_state=1 for 3 cycles, then 2 with o_halt_done=1; o_stall stays 1 and o_valid stays 0 from the cycle after capture.
- i_enable_pipeline=0 for 4 cycles during a load-use hazard -> outputs and o_stall_count frozen; resume gives an identical sequence.
- Assert reset asynchronously mid-DRAIN (between clock edges) -> all outputs 0 and o_state=0 immediately; i_flush=1 together with a hazard -> bubble, counter unchanged.
